da_matvec_engine: RTL and testbench
===================================

// Module: da_matvec_engine
// PURPOSE
//  Parametrised distributed-arithmetic engine computing Y = D*X for an N-point signed vector X and an NxN signed
//  coefficient matrix D held in a writable on-chip register file. One row at a time, bit-serial MSB-first
//  over XW cycles; each row result is streamed out on completion and collected in a flat result bus.
//  Next-generation transform core; N, widths and output scaling are parameters, coefficients are run-time loadable.
// PARAMETERS
//  N      8   vector length / matrix dimension (>=2)
//  XW     8   input sample width, two's complement
//  CW     8   coefficient width, two's complement
//  YW     12  output width
//  SHIFT  7   right shift applied to the accumulator before taking YW bits (SHIFT+YW <= AW)
//  derived: AW = XW+CW+$clog2(N) accumulator width; AB = $clog2(N*N) coefficient address width
// PORTS
//  clk        in   1        clock
//  reset      in   1        synchronous, active-high
//  coef_we    in   1        coefficient write strobe
//  coef_addr  in   AB       address r*N+c
//  coef_data  in   CW       coefficient D[r][c]
//  start      in   1        begin computation; sampled in IDLE only
//  x_in       in   N*XW     X, element c at [c*XW +: XW]
//  busy       out  1        high from the cycle after start acceptance until done
//  y_valid    out  1        one-cycle pulse per finished row
//  y_row      out  clog2N   row index of y_data
//  y_data     out  YW       row result
//  y_all      out  N*YW     all results, row r at [r*YW +: YW], held until next start
//  done       out  1        one-cycle pulse after last row
// BEHAVIOUR
//  Reset: clk and reset are decided as above. All outputs 0, state IDLE, coefficient file cleared to 0, x copy cleared.
//  Coef write: coef_we in IDLE writes coef_data to coef_addr on that edge; coef_we while busy is dropped; addr>=N*N ignored.
//  States: IDLE -start-> CALC(row 0, bit XW-1); CALC runs XW cycles; -> EMIT 1 cycle; EMIT -> CALC(row+1) or, after
//   row N-1, DONE 1 cycle -> IDLE.
//  On accepted start: x_in copied to internal register (later x_in changes ignored); row=0; busy=1 next cycle.
//  CALC bit b: PS = sum over c of (x[c][b] ? D[row][c] : 0), sign-extended to AW.
//   b=XW-1: acc = -PS; otherwise acc = 2*acc + PS. After XW cycles acc = exact sum_c D[row][c]*x[c].
//  EMIT: y_data = acc[SHIFT+YW-1:SHIFT] (floor, wrap; no saturation), y_row=row, y_valid=1, y_all slot row updated.
//  Timing: start sampled at edge 0 -> row r y_valid visible after edge (r+1)*(XW+1); done and busy=0 visible after edge
//   N*(XW+1)+1 (defaults: 9,18,...,72; done at 73). y_data/y_row hold last value between pulses.
//  start while busy: ignored. start and coef_we same IDLE edge: write committed and start accepted; new value used.
//  start in DONE cycle: ignored; accepted from IDLE next cycle. Reset mid-operation: abort, all outputs and
//   coefficients to reset values, no done pulse.
// CONFIGURATION
//  DA_ROUND_EN defined: EMIT slices (acc + 2^(SHIFT-1)) (round-half-up, wrap; SHIFT=0 means no add).
//  DA_ROUND_EN undefined: pure floor truncation as above. Timing identical in both builds.
// TESTING
//  1 reset held 3 cycles -> busy,done,y_valid,y_data,y_all all 0; coefficient readback via zero-result run: y_all=0.
//  2 D=64*I, X=[2,4,6,...,16], start -> y_valid pulses after edges 9..72, Y=[1,2,...,8]; done after edge 73.
//  3 D[0][0]=127 else 0, x0=-128 -> acc=-16256, y_data row0=12'hF81 (-127); other rows 0.
//  4 D all 1, X all -1 -> acc=-8, Y all 12'hFFF; with DA_ROUND_EN Y all 0.
//  5 start again at edge 20 of a run and coef_we during busy -> no restart, results unaffected, write lost.
//  6 reset asserted after 3rd y_valid -> outputs 0 next cycle, no done; fresh start then completes normally.

Source files
------------

// File: rtl/da_matvec_engine.sv
// Bit-serial distributed-arithmetic matrix-vector engine: Y = D*X, one row per XW+1 cycles.
// Build option DA_ROUND_EN: round-half-up ahead of the output slice instead of floor truncation.
module da_matvec_engine #(
  parameter  int N     = 8,
  parameter  int XW    = 8,
  parameter  int CW    = 8,
  parameter  int YW    = 12,
  parameter  int SHIFT = 7,
  localparam int AW    = XW + CW + $clog2(N),
  localparam int AB    = $clog2(N * N),
  localparam int RW    = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              coef_we,
  input  logic [AB-1:0]     coef_addr,
  input  logic [CW-1:0]     coef_data,
  input  logic              start,
  input  logic [N*XW-1:0]   x_in,
  output logic              busy,
  output logic              y_valid,
  output logic [RW-1:0]     y_row,
  output logic [YW-1:0]     y_data,
  output logic [N*YW-1:0]   y_all,
  output logic              done
);

  localparam int              BW    = (XW > 1) ? $clog2(XW) : 1;
  localparam logic [BW-1:0]   BTOP  = BW'(XW - 1);
  localparam logic [RW-1:0]   RLAST = RW'(N - 1);
`ifdef DA_ROUND_EN
  localparam logic [AW-1:0]   RND   = AW'((2 ** SHIFT) / 2);
`else
  localparam logic [AW-1:0]   RND   = '0;
`endif

  typedef enum logic [1:0] {IDLE, CALC, EMIT, DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   coef [N*N];
  logic [N*XW-1:0] xr;
  logic [RW-1:0]   row;
  logic [BW-1:0]   bitc;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   ps;
  logic            accept, calc_en, emit_en, fin_en;
  logic            coef_ok;

  assign coef_ok = (int'(coef_addr) < N * N);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (bitc == '0) state_nx = EMIT;
      EMIT:    state_nx = (row == RLAST) ? DONE : CALC;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    accept  = 1'b0;
    calc_en = 1'b0;
    emit_en = 1'b0;
    fin_en  = 1'b0;
    case (state)
      IDLE:    accept  = start;
      CALC:    calc_en = 1'b1;
      EMIT:    emit_en = 1'b1;
      DONE:    fin_en  = 1'b1;
      default: ;
    endcase
  end

  // Partial sum for the current bit plane: add D[row][c] wherever bit b of x[c] is set.
  always_comb begin
    logic [CW-1:0] cv;
    cv = '0;
    ps = '0;
    for (int unsigned c = 0; c < N; c++) begin
      cv = coef[AB'(int'(row) * N + int'(c))];
      if (xr[int'(c) * XW + int'(bitc)])
        ps = ps + {{(AW-CW){cv[CW-1]}}, cv};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      coef    <= '{default: '0};
      xr      <= '0;
      row     <= '0;
      bitc    <= '0;
      acc     <= '0;
      busy    <= 1'b0;
      y_valid <= 1'b0;
      y_row   <= '0;
      y_data  <= '0;
      y_all   <= '0;
      done    <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      done    <= 1'b0;
      if (state == IDLE && coef_we && coef_ok)
        coef[coef_addr] <= coef_data;
      if (accept) begin
        xr    <= x_in;
        row   <= '0;
        bitc  <= BTOP;
        busy  <= 1'b1;
        y_all <= '0;
      end
      // MSB plane carries negative weight in two's complement, so it seeds the accumulator negated.
      if (calc_en) begin
        acc  <= (bitc == BTOP) ? -ps : (acc << 1) + ps;
        bitc <= (bitc == '0) ? BTOP : bitc - 1'b1;
      end
      if (emit_en) begin
        y_valid                     <= 1'b1;
        y_row                       <= row;
        y_data                      <= YW'((acc + RND) >> SHIFT);
        y_all[int'(row) * YW +: YW] <= YW'((acc + RND) >> SHIFT);
        if (row != RLAST) row <= row + 1'b1;
      end
      if (fin_en) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_da_matvec_engine.sv
// Scoreboard bench for da_matvec_engine: arithmetic reference model, per-row latency and y_all checks.
module tb_da_matvec_engine;
  localparam int N      = 8;
  localparam int XW     = 8;
  localparam int CW     = 8;
  localparam int YW     = 12;
  localparam int SHIFT  = 7;
  localparam int RW     = $clog2(N);
  localparam int AB     = $clog2(N * N);
  localparam int ROWLAT = XW + 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            coef_we = 1'b0;
  logic [AB-1:0]   coef_addr = '0;
  logic [CW-1:0]   coef_data = '0;
  logic            start = 1'b0;
  logic [N*XW-1:0] x_in = '0;
  logic            busy, y_valid, done;
  logic [RW-1:0]   y_row;
  logic [YW-1:0]   y_data;
  logic [N*YW-1:0] y_all;

  da_matvec_engine #(.N(N), .XW(XW), .CW(CW), .YW(YW), .SHIFT(SHIFT)) dut (
    .clk(clk), .reset(reset), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .start(start), .x_in(x_in), .busy(busy), .y_valid(y_valid), .y_row(y_row),
    .y_data(y_data), .y_all(y_all), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            row;
    logic [YW-1:0] data;
    int            cyc;
  } exp_t;

  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;
  int              start_cyc = 0;
  int              vcount = 0;
  int              dm [N][N];
  int              xv [N];
  logic [N*YW-1:0] exp_all = '0;
  exp_t            sb [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [YW-1:0] model_row(input int r);
    longint acc;
    acc = 0;
    for (int c = 0; c < N; c++) acc += longint'(dm[r][c]) * longint'(xv[c]);
`ifdef DA_ROUND_EN
    if (SHIFT > 0) acc += (longint'(1) << (SHIFT - 1));
`endif
    acc = acc >>> SHIFT;
    return acc[YW-1:0];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && y_valid) begin
      vcount++;
      if (sb.size() == 0) check("unexpected_y_valid", 1, 0);
      else begin
        e = sb.pop_front();
        check("y_row", 64'(y_row), 64'(e.row));
        check("y_data", 64'(y_data), 64'(e.data));
        check("y_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic set_x();
    for (int c = 0; c < N; c++) x_in[c*XW +: XW] = XW'(xv[c]);
  endtask

  task automatic load_coefs();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = AB'(r * N + c);
        coef_data = CW'(dm[r][c]);
      end
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic start_run(input bit wr, input int wr_r, input int wr_c, input int wr_v);
    @(negedge clk);
    set_x();
    start = 1'b1;
    if (wr) begin
      coef_we   = 1'b1;
      coef_addr = AB'(wr_r * N + wr_c);
      coef_data = CW'(wr_v);
      dm[wr_r][wr_c] = wr_v;
    end
    @(posedge clk);
    #1;
    start     = 1'b0;
    coef_we   = 1'b0;
    start_cyc = cyc;
    for (int r = 0; r < N; r++) begin
      exp_t e;
      e.row  = r;
      e.data = model_row(r);
      e.cyc  = start_cyc + (r + 1) * ROWLAT;
      sb.push_back(e);
      exp_all[r*YW +: YW] = e.data;
    end
    check("busy_after_start", 64'(busy), 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 4 * N * ROWLAT) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 64'(done), 1);
    check("done_cycle", 64'(cyc), 64'(start_cyc + N * ROWLAT + 1));
    check("busy_at_done", 64'(busy), 0);
    check("scoreboard_drained", 64'(sb.size()), 0);
    for (int r = 0; r < N; r++) check("y_all", 64'(y_all[r*YW +: YW]), 64'(exp_all[r*YW +: YW]));
    @(negedge clk);
    check("done_one_cycle", 64'(done), 0);
  endtask

  task automatic fill_dm(input int diag, input int off);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) dm[r][c] = (r == c) ? diag : off;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, n;
    bit sawdone;
    logic [YW-1:0] v;

    // 1: reset and zero-coefficient run
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_y_valid", 64'(y_valid), 0);
    check("rst_y_data", 64'(y_data), 0);
    check("rst_y_row", 64'(y_row), 0);
    check("rst_y_all", 64'(y_all), 0);
    @(negedge clk);
    reset = 1'b0;
    fill_dm(0, 0);
    for (int c = 0; c < N; c++) xv[c] = int'($urandom_range(255)) - 128;
    start_run(0, 0, 0, 0);
    wait_done();

    // 2: D = 64*I, X = 2,4,...,16 -> Y = 1..8
    fill_dm(64, 0);
    for (int c = 0; c < N; c++) xv[c] = 2 * (c + 1);
    load_coefs();
    start_run(0, 0, 0, 0);
    wait_done();

    // 3: single extreme product
    fill_dm(0, 0);
    dm[0][0] = 127;
    xv[0] = -128;
    for (int c = 1; c < N; c++) xv[c] = int'($urandom_range(255)) - 128;
    load_coefs();
    start_run(0, 0, 0, 0);
    wait_done();
    check("t3_row0_const", 64'(y_all[YW-1:0]), 64'(12'hF81));

    // 4: D all 1, X all -1
    fill_dm(1, 1);
    for (int c = 0; c < N; c++) xv[c] = -1;
    load_coefs();
    start_run(0, 0, 0, 0);
    wait_done();
`ifdef DA_ROUND_EN
    v = '0;
`else
    v = '1;
`endif
    check("t4_row3_const", 64'(y_all[3*YW +: YW]), 64'(v));

    // 4b: coefficient write on the same edge as start is used by that run
    dm[N-1][N-1] = 0;
    load_coefs();
    start_run(1, N - 1, N - 1, -128);
    wait_done();

    // 5: start and coef_we while busy are ignored
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) dm[r][c] = int'($urandom_range(255)) - 128;
    dm[0][0] = 0;
    for (int c = 0; c < N; c++) xv[c] = int'($urandom_range(255)) - 128;
    xv[0] = 100;
    load_coefs();
    start_run(0, 0, 0, 0);
    while (cyc < start_cyc + 19) @(negedge clk);
    start     = 1'b1;
    coef_we   = 1'b1;
    coef_addr = '0;
    coef_data = 8'd127;
    @(posedge clk);
    #1;
    start   = 1'b0;
    coef_we = 1'b0;
    wait_done();
    start_run(0, 0, 0, 0);
    wait_done();

    // 6: reset after the third row result aborts the run
    fill_dm(64, 0);
    for (int c = 0; c < N; c++) xv[c] = int'($urandom_range(255)) - 128;
    load_coefs();
    start_run(0, 0, 0, 0);
    base = vcount;
    n = 0;
    while (vcount < base + 3 && n < 4 * N * ROWLAT) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t6_third_valid", 64'(vcount - base), 3);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t6_busy", 64'(busy), 0);
    check("t6_y_valid", 64'(y_valid), 0);
    check("t6_y_data", 64'(y_data), 0);
    check("t6_y_row", 64'(y_row), 0);
    check("t6_y_all", 64'(y_all), 0);
    check("t6_done", 64'(done), 0);
    sb.delete();
    exp_all = '0;
    fill_dm(0, 0);
    @(negedge clk);
    reset = 1'b0;
    sawdone = 1'b0;
    repeat (2 * N * ROWLAT) begin
      @(negedge clk);
      if (done) sawdone = 1'b1;
    end
    check("t6_no_done", 64'(sawdone), 0);
    start_run(0, 0, 0, 0);
    wait_done();
    fill_dm(64, 0);
    load_coefs();
    start_run(0, 0, 0, 0);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
